video_composite_timing: RTL and testbench

- Parametrised composite/RGB sync and timing generator, next generation of the fixed NTSC composite timing block.
- Horizontal and vertical geometry come from parameters, so NTSC- and PAL-class rasters are covered.
- Three runtime line modes: interlaced, 263-line progressive, and 262-line progressive (new).
- Mode changes are deferred to field boundaries. Feeds the line-buffer fetch logic (next_line/next_frame/next_pixel) and the video modulator (sync_n/burst/active).

---
 rtl/video_composite_timing_if.sv | 37 +++
 rtl/video_composite_timing.sv | 190 +++++++++++++++++++
 tb/tb_video_composite_timing.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/video_composite_timing_if.sv
// Composite timing bundle: runtime mode request in, sync,
// picture and fetch strobes out to modulator and line buffer.
interface video_composite_timing_if;
  logic [1:0]  mode;
  logic [1:0]  mode_cur;
  logic [10:0] h_pos;
  logic [9:0]  v_hl;
  logic        field;
  logic        sync_n;
  logic        hsync_n;
  logic        vsync_n;
  logic        burst;
  logic        active;
  logic        next_pixel;
  logic        next_line;
  logic        next_frame;
  logic        vblank_pulse;
  logic        current_field;

  modport master (
    input  mode,
    output mode_cur, h_pos, v_hl, field,
    output sync_n, hsync_n, vsync_n,
    output burst, active, next_pixel,
    output next_line, next_frame,
    output vblank_pulse, current_field
  );

  modport slave (
    output mode,
    input  mode_cur, h_pos, v_hl, field,
    input  sync_n, hsync_n, vsync_n,
    input  burst, active, next_pixel,
    input  next_line, next_frame,
    input  vblank_pulse, current_field
  );
endinterface

// File: rtl/video_composite_timing.sv
// Parametrised composite/RGB sync and timing generator with
// interlaced and two progressive line modes, field-deferred.
module video_composite_timing #(
  parameter int H_SYNC        = 118,
  parameter int H_BACK_PORCH  = 118,
  parameter int H_ACTIVE      = 1280,
  parameter int H_FRONT_PORCH = 72,
  parameter int H_VSYNC_LEN   = 678,
  parameter int H_EQ_LEN      = 58,
  parameter int H_BURST_START = 132,
  parameter int H_BURST_END   = 196,
  parameter int LINES         = 262,
  parameter int EQ_HL         = 6,
  parameter int V_ACT_START   = 42,
  parameter int V_ACT_HL      = 480,
  parameter int V_BURST_LEAD  = 20
) (
  input logic clk,
  input logic rst,
  video_composite_timing_if.master vif
);

  localparam int H_TOTAL = H_SYNC + H_BACK_PORCH
                         + H_ACTIVE + H_FRONT_PORCH;
  localparam int H_HALF  = H_TOTAL / 2;

  localparam logic [10:0] HT_M1 = 11'(H_TOTAL - 1);
  localparam logic [10:0] HH    = 11'(H_HALF);
  localparam logic [10:0] HH_M1 = 11'(H_HALF - 1);
  localparam logic [10:0] HS    = 11'(H_SYNC);
  localparam logic [10:0] HA0   = 11'(H_SYNC + H_BACK_PORCH);
  localparam logic [10:0] HA0_M1 = 11'(H_SYNC + H_BACK_PORCH - 1);
  localparam logic [10:0] HA1   = 11'(H_SYNC + H_BACK_PORCH + H_ACTIVE);
  localparam logic [10:0] VL    = 11'(H_VSYNC_LEN);
  localparam logic [10:0] HH_VL = 11'(H_HALF + H_VSYNC_LEN);
  localparam logic [10:0] EQL   = 11'(H_EQ_LEN);
  localparam logic [10:0] HH_EQ = 11'(H_HALF + H_EQ_LEN);
  localparam logic [10:0] BS    = 11'(H_BURST_START);
  localparam logic [10:0] BE    = 11'(H_BURST_END);

  localparam logic [9:0] EQ1    = 10'(EQ_HL);
  localparam logic [9:0] EQ2    = 10'(2 * EQ_HL);
  localparam logic [9:0] EQ3    = 10'(3 * EQ_HL);
  localparam logic [9:0] VAS    = 10'(V_ACT_START);
  localparam logic [9:0] VAL_M1 = 10'(V_ACT_HL - 1);
  localparam logic [9:0] VBL    = 10'(V_BURST_LEAD);
  localparam logic [9:0] FL_INT = 10'(2 * LINES);
  localparam logic [9:0] FL_P1  = 10'(2 * LINES + 1);
  localparam logic [9:0] FL_P0  = 10'(2 * LINES - 1);

  localparam logic [1:0] M_INT = 2'd0;
  localparam logic [1:0] M_P1  = 2'd1;
  localparam logic [1:0] M_P0  = 2'd2;

  logic [10:0] hc;
  logic [9:0]  vc;
  logic        fld;
  logic [1:0]  mc;
  logic        pend;
  logic        cf;

  logic [9:0]  f_last;
  logic [9:0]  s_act;
  logic [9:0]  v_end;
  logic        hl_end;
  logic        wrap;
  logic        last_fld;
  logic        v_act;
  logic        v_burst;
  logic        eq_reg;
  logic        vs_reg;
  logic        broad;
  logic        eqp;
  logic        hsp;
  logic        h_act;
  logic        h_burst;
  logic        nl_hit;
  logic        pend_set;
  logic        sync_c;

  assign hl_end   = (hc == HH_M1) || (hc == HT_M1);
  assign wrap     = hl_end && (vc == f_last);
  assign last_fld = (mc != M_INT) || fld;

  assign s_act   = VAS + {9'd0, fld & (mc == M_INT)};
  assign v_end   = s_act + VAL_M1;
  assign v_act   = (vc >= s_act) && (vc <= v_end);
  assign v_burst = (vc >= s_act - VBL) && (vc <= v_end);

  assign eq_reg = (vc < EQ1) || ((vc >= EQ2) && (vc < EQ3));
  assign vs_reg = (vc >= EQ1) && (vc < EQ2);

  assign broad = (hc < VL) || ((hc >= HH) && (hc < HH_VL));
  assign eqp   = (hc < EQL) || ((hc >= HH) && (hc < HH_EQ));
  assign hsp   = hc < HS;

  assign h_act   = (hc >= HA0) && (hc < HA1);
  assign h_burst = (hc >= BS) && (hc < BE);
  assign nl_hit  = hc == HA0_M1;

  assign pend_set = hl_end && (vc == s_act - 10'd1);

  // Last half-line index of the field for the mode in effect
  always_comb begin
    f_last = FL_INT;
    unique case (1'b1)
      (mc == M_P1): f_last = FL_P1;
      (mc == M_P0): f_last = FL_P0;
      default:      f_last = FL_INT;
    endcase
  end

  // Composite sync picks pulse shape by vertical region
  always_comb begin
    sync_c = hsp;
    unique case (1'b1)
      vs_reg:  sync_c = broad;
      eq_reg:  sync_c = eqp;
      default: sync_c = hsp;
    endcase
  end

  // Raster counters, field sequencing and deferred mode latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hc  <= '0;
      vc  <= '0;
      fld <= 1'b0;
      mc  <= M_INT;
    end else begin
      hc <= (hc == HT_M1) ? 11'd0 : hc + 11'd1;
      if (hl_end)
        vc <= wrap ? 10'd0 : vc + 10'd1;
      if (wrap) begin
        fld <= (mc == M_INT) ? ~fld : 1'b0;
        if (last_fld)
          mc <= (vif.mode == 2'd3) ? M_INT : vif.mode;
      end
    end
  end

  // Arms the frame strobe one half-line before picture start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= 1'b0;
      cf   <= 1'b0;
    end else if (pend_set) begin
      pend <= 1'b1;
      cf   <= fld;
    end else if (pend && nl_hit) begin
      pend <= 1'b0;
    end
  end

  // Output register stage keeps every output on the same clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vif.mode_cur      <= 2'd0;
      vif.h_pos         <= '0;
      vif.v_hl          <= '0;
      vif.field         <= 1'b0;
      vif.sync_n        <= 1'b1;
      vif.hsync_n       <= 1'b1;
      vif.vsync_n       <= 1'b1;
      vif.burst         <= 1'b0;
      vif.active        <= 1'b0;
      vif.next_pixel    <= 1'b0;
      vif.next_line     <= 1'b0;
      vif.next_frame    <= 1'b0;
      vif.vblank_pulse  <= 1'b0;
      vif.current_field <= 1'b0;
    end else begin
      vif.mode_cur      <= mc;
      vif.h_pos         <= hc;
      vif.v_hl          <= vc;
      vif.field         <= fld;
      vif.sync_n        <= ~sync_c;
      vif.hsync_n       <= ~hsp;
      vif.vsync_n       <= ~vs_reg;
      vif.burst         <= v_burst & h_burst;
      vif.active        <= h_act & v_act;
      vif.next_pixel    <= h_act;
      vif.next_line     <= nl_hit;
      vif.next_frame    <= pend & nl_hit;
      vif.vblank_pulse  <= wrap;
      vif.current_field <= cf;
    end
  end

endmodule

// File: tb/tb_video_composite_timing.sv
// Directed bench on a reduced raster: 28 clocks/line,
// 20 lines/field, so whole fields fit in a few hundred clocks.
module tb_video_composite_timing;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  video_composite_timing_if vif();

  video_composite_timing #(
    .H_SYNC(4), .H_BACK_PORCH(4),
    .H_ACTIVE(16), .H_FRONT_PORCH(4),
    .H_VSYNC_LEN(10), .H_EQ_LEN(2),
    .H_BURST_START(5), .H_BURST_END(7),
    .LINES(20), .EQ_HL(2),
    .V_ACT_START(8), .V_ACT_HL(24),
    .V_BURST_LEAD(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .vif(vif.master)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int idx, n_vb, vb_idx, n_slo, n_svs, n_seq, n_vlo;
  int n_act, amin, amax, n_bur, n_bbad;
  int n_nf, nf_h, nf_v, nf_cf, n_nl, n_nlbad, n_np;
  int n_f1, hmax, f0_h, f0_v, f0_f, f0_s;
  int n_mc[4];

  task automatic check(string tag, int got, int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int flags();
    return int'({vif.sync_n, vif.hsync_n, vif.vsync_n,
                 vif.burst, vif.active, vif.next_pixel,
                 vif.next_line, vif.next_frame,
                 vif.vblank_pulse, vif.current_field,
                 vif.field, vif.mode_cur});
  endfunction

  task automatic clr();
    idx = 0; n_vb = 0; vb_idx = -1; n_slo = 0;
    n_svs = 0; n_seq = 0; n_vlo = 0; n_act = 0;
    amin = 9999; amax = -1; n_bur = 0; n_bbad = 0;
    n_nf = 0; nf_h = -1; nf_v = -1; nf_cf = -1;
    n_nl = 0; n_nlbad = 0; n_np = 0; n_f1 = 0;
    hmax = 0;
    for (int i = 0; i < 4; i++) n_mc[i] = 0;
  endtask

  task automatic tick();
    int h;
    int v;
    @(negedge clk);
    h = int'(vif.h_pos);
    v = int'(vif.v_hl);
    if (idx == 0) begin
      f0_h = h; f0_v = v;
      f0_f = int'(vif.field);
      f0_s = int'(vif.sync_n);
    end
    if (h > hmax) hmax = h;
    if (vif.vblank_pulse) begin n_vb++; vb_idx = idx; end
    if (!vif.sync_n) begin
      n_slo++;
      if (v == 2 || v == 3) n_svs++;
      if (v == 0 || v == 1 || v == 4 || v == 5) n_seq++;
    end
    if (!vif.vsync_n) n_vlo++;
    if (vif.active) begin
      n_act++;
      if (v < amin) amin = v;
      if (v > amax) amax = v;
    end
    if (vif.burst) begin
      n_bur++;
      if (v < 6) n_bbad++;
    end
    if (vif.next_frame) begin
      n_nf++; nf_h = h; nf_v = v;
      nf_cf = int'(vif.current_field);
    end
    if (vif.next_line) begin
      n_nl++;
      if (h != 7) n_nlbad++;
    end
    if (vif.next_pixel) n_np++;
    if (vif.field) n_f1++;
    n_mc[vif.mode_cur]++;
    idx++;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    vif.mode = 2'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_hpos", int'(vif.h_pos), 0);
    check("rst_vhl", int'(vif.v_hl), 0);
    check("rst_flags", flags(), 7168);
    rst = 1'b0;

    // mode 0, field 0
    clr(); run(574);
    check("m0f0_first_h", f0_h, 0);
    check("m0f0_first_v", f0_v, 0);
    check("m0f0_first_eq", f0_s, 0);
    check("m0f0_vb_cnt", n_vb, 1);
    check("m0f0_vb_idx", vb_idx, 573);
    check("m0f0_hmax", hmax, 27);
    check("m0f0_sync_lo", n_slo, 100);
    check("m0f0_sync_vs", n_svs, 20);
    check("m0f0_sync_eq", n_seq, 8);
    check("m0f0_vsync_lo", n_vlo, 28);
    check("m0f0_act", n_act, 192);
    check("m0f0_act_min", amin, 8);
    check("m0f0_act_max", amax, 31);
    check("m0f0_burst", n_bur, 26);
    check("m0f0_burst_bad", n_bbad, 0);
    check("m0f0_nf_cnt", n_nf, 1);
    check("m0f0_nf_h", nf_h, 7);
    check("m0f0_nf_v", nf_v, 8);
    check("m0f0_nf_cf", nf_cf, 0);
    check("m0f0_nl_cnt", n_nl, 21);
    check("m0f0_nl_bad", n_nlbad, 0);
    check("m0f0_npix", n_np, 326);
    check("m0f0_fld1", n_f1, 0);

    // mode 0, field 1 starts mid-line
    clr(); run(574);
    check("m0f1_first_h", f0_h, 14);
    check("m0f1_first_v", f0_v, 0);
    check("m0f1_first_f", f0_f, 1);
    check("m0f1_vb_idx", vb_idx, 573);
    check("m0f1_sync_lo", n_slo, 96);
    check("m0f1_sync_vs", n_svs, 20);
    check("m0f1_act", n_act, 192);
    check("m0f1_act_min", amin, 9);
    check("m0f1_act_max", amax, 32);
    check("m0f1_burst", n_bur, 26);
    check("m0f1_burst_bad", n_bbad, 0);
    check("m0f1_nf_h", nf_h, 7);
    check("m0f1_nf_v", nf_v, 9);
    check("m0f1_nf_cf", nf_cf, 1);
    check("m0f1_fld1", n_f1, 574);

    // request mode 2 mid field 0: must wait for field 1 wrap
    clr(); run(300);
    vif.mode = 2'd2;
    run(274);
    check("sw_f0_first_f", f0_f, 0);
    check("sw_f0_first_h", f0_h, 0);
    check("sw_f0_vb_idx", vb_idx, 573);
    check("sw_f0_mc0", n_mc[0], 574);
    clr(); run(574);
    check("sw_f1_first_f", f0_f, 1);
    check("sw_f1_vb_idx", vb_idx, 573);
    check("sw_f1_mc0", n_mc[0], 574);

    // mode 2 fields
    clr(); run(560);
    check("m2a_first_h", f0_h, 0);
    check("m2a_first_f", f0_f, 0);
    check("m2a_vb_cnt", n_vb, 1);
    check("m2a_vb_idx", vb_idx, 559);
    check("m2a_mc2", n_mc[2], 560);
    check("m2a_fld1", n_f1, 0);
    check("m2a_act", n_act, 192);
    check("m2a_act_min", amin, 8);
    check("m2a_act_max", amax, 31);
    check("m2a_sync_lo", n_slo, 96);
    vif.mode = 2'd1;
    clr(); run(560);
    check("m2b_vb_idx", vb_idx, 559);
    check("m2b_mc2", n_mc[2], 560);

    // mode 1 fields
    for (int k = 0; k < 2; k++) begin
      clr(); run(588);
      check("m1_first_h", f0_h, 0);
      check("m1_vb_cnt", n_vb, 1);
      check("m1_vb_idx", vb_idx, 587);
      check("m1_mc1", n_mc[1], 588);
      check("m1_fld1", n_f1, 0);
      check("m1_act", n_act, 192);
      check("m1_act_min", amin, 8);
      check("m1_act_max", amax, 31);
      check("m1_nf_cnt", n_nf, 1);
      check("m1_nf_h", nf_h, 7);
      check("m1_nf_v", nf_v, 8);
      check("m1_sync_lo", n_slo, 100);
    end

    // asynchronous reset mid-line
    clr(); run(300);
    check("pre_rst_h", int'(vif.h_pos), 19);
    check("pre_rst_v", int'(vif.v_hl), 21);
    #3 rst = 1'b1;
    #1;
    check("arst_hpos", int'(vif.h_pos), 0);
    check("arst_vhl", int'(vif.v_hl), 0);
    check("arst_flags", flags(), 7168);
    vif.mode = 2'd0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clr(); run(574);
    check("post_first_h", f0_h, 0);
    check("post_first_eq", f0_s, 0);
    check("post_vb_cnt", n_vb, 1);
    check("post_vb_idx", vb_idx, 573);
    check("post_mc0", n_mc[0], 574);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
